// File: rtl/neo_pkg.sv
// rtl/neo_pkg.sv - shared NeoPixel state encoding and line timing constants
package neo_pkg;

  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_HIGH    = 3'd2,
    ST_LOW     = 3'd3,
    ST_DISCARD = 3'd4
  } neo_state_e;

  localparam int NEO_LATCH_CYCLES = 2500;
  localparam int NEO_T1H = 35;
  localparam int NEO_T1L = 30;
  localparam int NEO_T0H = 18;
  localparam int NEO_T0L = 40;

endpackage

// File: rtl/neo_sync.sv
// rtl/neo_sync.sv - two-flop synchronizer with rise/fall detect on the synchronized line
module neo_sync (
  input  logic clock,
  input  logic reset,
  input  logic neo_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic s_q;
  logic s_d_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      s_q    <= 1'b0;
      s_d_q  <= 1'b0;
    end else begin
      meta_q <= neo_i;
      s_q    <= meta_q;
      s_d_q  <= s_q;
    end
  end

  assign s_o    = s_q;
  assign rise_o = s_q & ~s_d_q;
  assign fall_o = ~s_q & s_d_q;

endmodule

// File: rtl/neo_pixel_receiver.sv
// rtl/neo_pixel_receiver.sv - decodes a NeoPixel serial stream into 24-bit pixel words
module neo_pixel_receiver
  import neo_pkg::*;
#(
  parameter int NUM_PIXELS   = 5,
  parameter int BIT_THRESH   = 27,
  parameter int MIN_HIGH     = 8,
  parameter int MAX_HIGH     = 50,
  parameter int LATCH_CYCLES = NEO_LATCH_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        neo_in,
  output logic        pixel_valid,
  output logic [23:0] pixel_data,
  output logic [2:0]  pixel_num,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [3:0]  frame_pixels
);

  localparam int HI_W = $clog2(MAX_HIGH + 2);
  localparam int LO_W = $clog2(LATCH_CYCLES + 1);

  logic s, rise, fall;

  neo_sync u_sync (
    .clock  (clock),
    .reset  (reset),
    .neo_i  (neo_in),
    .s_o    (s),
    .rise_o (rise),
    .fall_o (fall)
  );

  neo_state_e        state_q;
  logic [HI_W-1:0]   hi_cnt_q;
  logic [LO_W-1:0]   lo_cnt_q;
  logic [4:0]        bit_cnt_q;
  logic [3:0]        pix_cnt_q;
  logic [23:0]       shift_q;
  logic              bad_q;
  logic              any_bits_q;
  logic              pixel_valid_q, frame_done_q, frame_ok_q;
  logic [23:0]       pixel_data_q;
  logic [2:0]        pixel_num_q;
  logic [3:0]        frame_pixels_q;

  logic              bit_d;
  logic [23:0]       word_d;
  logic              latch_d;

  // Shifting in at the MSB leaves the first received bit in bit 0 after 24 bits.
  always_comb begin
    bit_d   = (hi_cnt_q >= HI_W'(BIT_THRESH));
    word_d  = {bit_d, shift_q[23:1]};
    latch_d = ((state_q == ST_LOW) || (state_q == ST_DISCARD)) && !s &&
              (lo_cnt_q == LO_W'(LATCH_CYCLES - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_SYNC;
      hi_cnt_q       <= '0;
      lo_cnt_q       <= '0;
      bit_cnt_q      <= '0;
      pix_cnt_q      <= '0;
      shift_q        <= '0;
      bad_q          <= 1'b0;
      any_bits_q     <= 1'b0;
      pixel_valid_q  <= 1'b0;
      pixel_data_q   <= '0;
      pixel_num_q    <= '0;
      frame_done_q   <= 1'b0;
      frame_ok_q     <= 1'b0;
      frame_pixels_q <= '0;
    end else begin
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      case (state_q)
        ST_SYNC: begin
          if (s) begin
            lo_cnt_q <= '0;
          end else if (lo_cnt_q == LO_W'(LATCH_CYCLES - 1)) begin
            lo_cnt_q <= '0;
            state_q  <= ST_IDLE;
          end else begin
            lo_cnt_q <= lo_cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (rise) begin
            hi_cnt_q <= HI_W'(1);
            state_q  <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (s) begin
            if (hi_cnt_q >= HI_W'(MAX_HIGH)) begin
              bad_q    <= 1'b1;
              lo_cnt_q <= '0;
              state_q  <= ST_DISCARD;
            end else begin
              hi_cnt_q <= hi_cnt_q + 1'b1;
            end
          end else if (fall) begin
            lo_cnt_q <= LO_W'(1);
            if (hi_cnt_q < HI_W'(MIN_HIGH)) begin
              bad_q   <= 1'b1;
              state_q <= ST_DISCARD;
            end else begin
              any_bits_q <= 1'b1;
              shift_q    <= word_d;
              state_q    <= ST_LOW;
              if (bit_cnt_q == 5'd23) begin
                bit_cnt_q <= '0;
                if (pix_cnt_q < 4'(NUM_PIXELS)) begin
                  pixel_valid_q <= 1'b1;
                  pixel_data_q  <= word_d;
                  pixel_num_q   <= pix_cnt_q[2:0];
                  pix_cnt_q     <= pix_cnt_q + 1'b1;
                end else begin
                  bad_q <= 1'b1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
        end
        ST_LOW: begin
          if (rise) begin
            hi_cnt_q <= HI_W'(1);
            state_q  <= ST_HIGH;
          end else if (lo_cnt_q != LO_W'(LATCH_CYCLES)) begin
            lo_cnt_q <= lo_cnt_q + 1'b1;
          end
        end
        ST_DISCARD: begin
          if (s) begin
            lo_cnt_q <= '0;
          end else if (lo_cnt_q != LO_W'(LATCH_CYCLES)) begin
            lo_cnt_q <= lo_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_SYNC;
      endcase

      // A discarded frame still reports itself so the host sees the error.
      if (latch_d) begin
        state_q  <= ST_IDLE;
        lo_cnt_q <= '0;
        if (any_bits_q || bad_q) begin
          frame_done_q   <= 1'b1;
          frame_ok_q     <= !bad_q && (bit_cnt_q == 5'd0);
          frame_pixels_q <= pix_cnt_q;
        end
        bit_cnt_q  <= '0;
        pix_cnt_q  <= '0;
        bad_q      <= 1'b0;
        any_bits_q <= 1'b0;
      end
    end
  end

  assign pixel_valid  = pixel_valid_q;
  assign pixel_data   = pixel_data_q;
  assign pixel_num    = pixel_num_q;
  assign frame_done   = frame_done_q;
  assign frame_ok     = frame_ok_q;
  assign frame_pixels = frame_pixels_q;

endmodule

// File: tb/tb_neo_pixel_receiver.sv
// tb/tb_neo_pixel_receiver.sv - directed self-checking bench for neo_pixel_receiver
module tb_neo_pixel_receiver;
  import neo_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        neo_in = 1'b0;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic [2:0]  pixel_num;
  logic        frame_done;
  logic        frame_ok;
  logic [3:0]  frame_pixels;

  int n_checks = 0;
  int n_pass   = 0;
  int coincide = 0;
  logic [26:0] pix_q[$];
  logic [4:0]  frm_q[$];

  always #10 clock = ~clock;

  neo_pixel_receiver dut (
    .clock        (clock),
    .reset        (reset),
    .neo_in       (neo_in),
    .pixel_valid  (pixel_valid),
    .pixel_data   (pixel_data),
    .pixel_num    (pixel_num),
    .frame_done   (frame_done),
    .frame_ok     (frame_ok),
    .frame_pixels (frame_pixels)
  );

  always @(negedge clock) begin
    if (pixel_valid) pix_q.push_back({pixel_num, pixel_data});
    if (frame_done)  frm_q.push_back({frame_ok, frame_pixels});
    if (pixel_valid && frame_done) coincide++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    neo_in = 1'b1;
    cyc(b ? NEO_T1H : NEO_T0H);
    neo_in = 1'b0;
    cyc(b ? NEO_T1L : NEO_T0L);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic latch_gap();
    neo_in = 1'b0;
    cyc(NEO_LATCH_CYCLES + 100);
  endtask

  function automatic logic [26:0] pix_at(input int k);
    return (pix_q.size() > k) ? pix_q[k] : 27'h7FFFFFF;
  endfunction

  function automatic logic [4:0] frm_at(input int k);
    return (frm_q.size() > k) ? frm_q[k] : 5'h1F;
  endfunction

  task automatic clear_logs();
    pix_q.delete();
    frm_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_outs"}, {pixel_valid, frame_done, frame_ok, frame_pixels, pixel_num}, 32'd0);
    check({tag, "_data"}, {8'd0, pixel_data}, 32'd0);
  endtask

  logic [23:0] words [6];

  initial begin
    words[0] = 24'h123456;
    words[1] = 24'hABCDEF;
    words[2] = 24'h000001;
    words[3] = 24'h800000;
    words[4] = 24'h5A5AA5;
    words[5] = 24'hFFFFFF;

    cyc(3);
    check_outputs_zero("reset_held");
    reset = 1'b0;
    cyc(2);
    check_outputs_zero("reset_rel");

    // single pixel 0x00FF00
    cyc(NEO_LATCH_CYCLES + 20);
    clear_logs();
    send_bits(24'h00FF00, 24);
    latch_gap();
    check("p1_cnt", pix_q.size(), 1);
    check("p1_pix", pix_at(0), {3'd0, 24'h00FF00});
    check("p1_frm_cnt", frm_q.size(), 1);
    check("p1_frm", frm_at(0), {1'b1, 4'd1});
    check("p1_hold", {frame_ok, frame_pixels, pixel_data}, {1'b1, 4'd1, 24'h00FF00});

    // five clean pixels
    clear_logs();
    for (int p = 0; p < 5; p++) send_bits(words[p], 24);
    latch_gap();
    check("p5_cnt", pix_q.size(), 5);
    for (int p = 0; p < 5; p++) check($sformatf("p5_pix%0d", p), pix_at(p), {3'(p), words[p]});
    check("p5_frm_cnt", frm_q.size(), 1);
    check("p5_frm", frm_at(0), {1'b1, 4'd5});

    // short glitch mid-pixel discards the rest of the frame
    clear_logs();
    send_bits(words[1], 24);
    send_bits(words[0], 10);
    neo_in = 1'b1; cyc(5);
    neo_in = 1'b0; cyc(40);
    send_bits(words[4], 24);
    latch_gap();
    check("gl_cnt", pix_q.size(), 1);
    check("gl_pix", pix_at(0), {3'd0, words[1]});
    check("gl_frm", frm_at(0), {1'b0, 4'd1});

    // six pixels: sixth ignored, frame bad, count saturates
    clear_logs();
    for (int p = 0; p < 6; p++) send_bits(words[p], 24);
    latch_gap();
    check("p6_cnt", pix_q.size(), 5);
    check("p6_last", pix_at(4), {3'd4, words[4]});
    check("p6_frm_cnt", frm_q.size(), 1);
    check("p6_frm", frm_at(0), {1'b0, 4'd5});

    // partial pixel of 12 bits
    clear_logs();
    send_bits(24'h000FFF, 12);
    latch_gap();
    check("pt_cnt", pix_q.size(), 0);
    check("pt_frm", frm_at(0), {1'b0, 4'd0});

    // reset during bit 10 of the next frame
    clear_logs();
    send_bits(24'hFFFFFF, 9);
    neo_in = 1'b1; cyc(10);
    reset = 1'b1; cyc(2);
    check_outputs_zero("rs_mid");
    reset = 1'b0;
    cyc(25);
    neo_in = 1'b0; cyc(NEO_T1L);
    send_bits(24'hFFFFFF, 14);
    latch_gap();
    check("rs_nostrobe", pix_q.size() + frm_q.size(), 0);
    send_bits(24'hC0FFEE, 24);
    latch_gap();
    check("rs_pix", pix_at(0), {3'd0, 24'hC0FFEE});
    check("rs_frm", frm_at(0), {1'b1, 4'd1});

    // overlong high pulse
    clear_logs();
    send_bits(24'h000005, 3);
    neo_in = 1'b1; cyc(60);
    neo_in = 1'b0;
    latch_gap();
    check("lh_cnt", pix_q.size(), 0);
    check("lh_frm_cnt", frm_q.size(), 1);
    check("lh_frm", frm_at(0), {1'b0, 4'd0});

    check("no_coincide", coincide, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
